irq_ctrl: RTL



---
 rtl/irq_ctrl_pkg.sv | 21 ++
 rtl/irq_sync_chain.sv | 31 +++
 rtl/irq_ctrl.sv | 72 +++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register offsets, vector format and priority encoder shared by the interrupt controller
package irq_ctrl_pkg;

    localparam int MAX_SRC = 8;
    localparam int VEC_ACTIVE_BIT = 7;

    typedef enum logic [1:0] {
        REG_PEND = 2'd0,
        REG_MASK = 2'd1,
        REG_MODE = 2'd2,
        REG_VEC  = 2'd3
    } reg_e;

    // Lowest active index wins; the loop runs downward so the last hit is the lowest.
    function automatic logic [7:0] vec_encode(input logic [MAX_SRC-1:0] act);
        vec_encode = 8'h00;
        for (int i = MAX_SRC - 1; i >= 0; i--)
            if (act[i]) vec_encode = {1'b1, 4'b0000, 3'(i)};
    endfunction

endpackage

// File: rtl/irq_sync_chain.sv
// irq_sync_chain: per-bit flop synchronizer resetting to ones; zero stages is a straight wire
module irq_sync_chain #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_clk_reset;
            assign unused_clk_reset = clk ^ reset;
            assign q = d;
        end else begin : g_chain
            logic [WIDTH-1:0] stage [STAGES];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < STAGES; k++) stage[k] <= '1;
                end else begin
                    stage[0] <= d;
                    for (int k = 1; k < STAGES; k++) stage[k] <= stage[k-1];
                end
            end
            assign q = stage[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: maskable interrupt controller with level/edge capture and a priority vector for the 65C02 bus
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int         N_SRC       = 8,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RESET_MASK  = 8'h00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             we,
    input  logic [1:0]       rs,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    input  logic [N_SRC-1:0] src_irq_n,
    output logic             irq
);

    localparam logic [MAX_SRC-1:0] VALID = MAX_SRC'((1 << N_SRC) - 1);

    logic [N_SRC-1:0]   s_sync;
    logic [MAX_SRC-1:0] s, s_prev, a, rise, pend, mask, mode, act, w1c, ack, pend_nxt;
    logic [7:0]         vec, rd_data;
    logic               rd, wr;

    irq_sync_chain #(.WIDTH(N_SRC), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (src_irq_n),
        .q     (s_sync)
    );

    // Unused upper source slots look permanently deasserted.
    always_comb begin
        s = '1;
        s[N_SRC-1:0] = s_sync;
    end

    assign rd   = cs & ~we;
    assign wr   = cs & we;
    assign a    = ~s;
    assign rise = a & s_prev;
    assign act  = pend & mask;
    assign vec  = vec_encode(act);
    assign w1c  = (wr && rs == REG_PEND) ? din : '0;
    assign ack  = (rd && rs == REG_VEC && vec[VEC_ACTIVE_BIT]) ? MAX_SRC'(1) << vec[2:0] : '0;
    // Edge bits: a new edge beats any same-cycle clear; level bits just follow the input.
    assign pend_nxt = VALID & ((~mode & a) | (mode & (rise | (pend & ~(w1c | ack)))));
    assign rd_data  = rs == REG_PEND ? pend :
                      rs == REG_MASK ? mask :
                      rs == REG_MODE ? mode : vec;

    always_ff @(posedge clk) begin
        if (reset) begin
            s_prev <= '1;
            pend   <= '0;
            mask   <= RESET_MASK & VALID;
            mode   <= '0;
            dout   <= 8'h00;
            irq    <= 1'b0;
        end else begin
            s_prev <= s;
            pend   <= pend_nxt;
            irq    <= |act;
            if (wr && rs == REG_MASK) mask <= din & VALID;
            if (wr && rs == REG_MODE) mode <= din & VALID;
            if (rd) dout <= rd_data;
        end
    end

endmodule
